// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI burst controller.
// No logic; types only.
// No flow control of its own.
package spi_pkg;

   localparam int SPI_DWIDTH_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_CAPTURE
   } spi_state_e;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Bundles the upstream TX push, downstream RX handshake and spi_core strobes.
// Wires only, no latency.
// Backpressure travels on tx_ready / rx_ready.
interface spi_burst_ctrl_if
   import spi_pkg::*;
#(
   parameter int DWIDTH = SPI_DWIDTH_DEF
) ();

   logic              tx_valid;
   logic              tx_ready;
   logic [DWIDTH-1:0] tx_data;

   logic              rx_valid;
   logic              rx_ready;
   logic [DWIDTH-1:0] rx_data;

   logic              core_cs;
   logic              core_rd;
   logic              core_wr;
   logic [DWIDTH-1:0] core_din;
   logic [DWIDTH-1:0] core_dout;
   logic              core_done;

   // Controller side
   modport master (
      input  tx_valid, tx_data, rx_ready, core_dout, core_done,
      output tx_ready, rx_valid, rx_data, core_cs, core_rd, core_wr, core_din
   );

   // Environment side: upstream producer, downstream consumer and spi_core
   modport slave (
      output tx_valid, tx_data, rx_ready, core_dout, core_done,
      input  tx_ready, rx_valid, rx_data, core_cs, core_rd, core_wr, core_din
   );

endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous TX word FIFO, head word visible combinationally on rd_dat.
// Push-to-visible latency 1 cycle.
// wr_rdy = not full; a push against a full FIFO is refused even if a pop happens that cycle.
module spi_sync_fifo
   import spi_pkg::*;
#(
   parameter int DWIDTH = SPI_DWIDTH_DEF,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_vld,
   output logic              wr_rdy,
   input  logic [DWIDTH-1:0] wr_dat,
   output logic              rd_vld,
   input  logic              rd_rdy,
   output logic [DWIDTH-1:0] rd_dat
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] mem_d [DEPTH];
   logic              push, pop;

   assign wr_rdy = (cnt_q != CNT_FULL);
   assign rd_vld = (cnt_q != '0);
   assign rd_dat = mem_q[rd_ptr_q];
   assign push   = wr_vld & wr_rdy;
   assign pop    = rd_vld & rd_rdy;

   // Next pointers, occupancy and storage; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_dat;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Drains a TX FIFO into spi_core one word per transfer and returns each result on rx.
// Push into empty FIFO (IDLE, core_done=1) -> core_wr 1 cycle later; back-to-back bursts skip IDLE.
// Stalls in CAPTURE while rx holds an unconsumed word; optional SPI_BURST_LOOPCHK_EN adds sticky err.
module spi_burst_ctrl
   import spi_pkg::*;
#(
   parameter int DWIDTH = SPI_DWIDTH_DEF,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   spi_burst_ctrl_if.master  bus,
   output logic              busy
`ifdef SPI_BURST_LOOPCHK_EN
   ,
   output logic              err
`endif
);

   spi_state_e        state_q, state_d;
   logic [DWIDTH-1:0] core_din_q, core_din_d;
   logic [DWIDTH-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              fifo_vld;
   logic              fifo_pop;
   logic [DWIDTH-1:0] fifo_dat;
   logic              cap_ok;

   spi_sync_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (bus.tx_valid),
      .wr_rdy (bus.tx_ready),
      .wr_dat (bus.tx_data),
      .rd_vld (fifo_vld),
      .rd_rdy (fifo_pop),
      .rd_dat (fifo_dat)
   );

   // The rx slot can take a new word when empty or being drained this cycle
   assign cap_ok = !rx_valid_q || bus.rx_ready;

   // Next state, FIFO pop and rx slot; the pop happens on entry to LOAD so core_din is valid during LOAD
   always_comb begin
      state_d    = state_q;
      core_din_d = core_din_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      fifo_pop   = 1'b0;
      if (rx_valid_q && bus.rx_ready) begin
         rx_valid_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (fifo_vld && bus.core_done) begin
               fifo_pop   = 1'b1;
               core_din_d = fifo_dat;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (!bus.core_done) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.core_done) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (cap_ok) begin
               rx_data_d  = bus.core_dout;
               rx_valid_d = 1'b1;
               if (fifo_vld && bus.core_done) begin
                  fifo_pop   = 1'b1;
                  core_din_d = fifo_dat;
                  state_d    = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         core_din_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         core_din_q <= core_din_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign bus.core_cs  = (state_q == ST_LOAD);
   assign bus.core_wr  = (state_q == ST_LOAD);
   assign bus.core_rd  = 1'b0;
   assign bus.core_din = core_din_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign busy         = (state_q != ST_IDLE) || fifo_vld;

`ifdef SPI_BURST_LOOPCHK_EN
   // The loopback echoes the previous transfer's word, so each capture is checked
   // against the word sent last time; nothing has been sent before the first capture.
   logic [DWIDTH-1:0] prev_q, prev_d;
   logic              have_prev_q, have_prev_d;
   logic              err_q, err_d;
   logic              cap_fire;

   assign cap_fire = (state_q == ST_CAPTURE) && cap_ok;

   // Compare on capture, then remember the word that was just sent
   always_comb begin
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      err_d       = err_q;
      if (cap_fire) begin
         if (have_prev_q && (bus.core_dout != prev_q)) begin
            err_d = 1'b1;
         end
         prev_d      = core_din_q;
         have_prev_d = 1'b1;
      end
   end

   // Loopback check registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         err_q       <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural spi_core and an rx scoreboard.
// Core model: done drops on the negedge seen in LOAD, returns CORE_LAT negedges later.
// Default core returns ~din; with SPI_BURST_LOOPCHK_EN it echoes the previous word.
module tb_spi_burst_ctrl;
   import spi_pkg::*;

   localparam int DW       = 8;
   localparam int CORE_LAT = 3;

   logic clk = 1'b0;
   logic rst;
   logic busy;
`ifdef SPI_BURST_LOOPCHK_EN
   logic err;
   logic corrupt;
   logic [DW-1:0] core_shreg;
   logic [DW-1:0] last_sent;
`endif

   spi_burst_ctrl_if #(.DWIDTH(DW)) bus ();

   spi_burst_ctrl #(.DWIDTH(DW), .DEPTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
`ifdef SPI_BURST_LOOPCHK_EN
      ,
      .err  (err)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] core_sent;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_push(input logic [DW-1:0] w);
`ifdef SPI_BURST_LOOPCHK_EN
      exp_q.push_back(last_sent ^ (corrupt ? 8'h01 : 8'h00));
      last_sent = w;
`else
      exp_q.push_back(~w);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one word and hold it until accepted; returns 1ns after the accepting edge
   task automatic push_word(input logic [DW-1:0] w);
      logic ok;
      ok = 1'b0;
      exp_push(w);
      bus.tx_valid = 1'b1;
      bus.tx_data  = w;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.tx_ready === 1'b1) ok = 1'b1;
      end
      check("push_accepted", 32'(ok), 32'h1);
      if (ok) tick();
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && bus.rx_valid === 1'b0 && bus.core_done === 1'b1 && exp_q.size() == 0)
            ok = 1'b1;
      end
      check(tag, 32'(ok), 32'h1);
   endtask

   task automatic wait_rx_valid(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.rx_valid === 1'b1) ok = 1'b1;
      end
      check(tag, 32'(ok), 32'h1);
   endtask

   // Behavioural spi_core
   always @(negedge clk) begin
      if (bus.core_wr === 1'b1) begin
         core_sent     = bus.core_din;
         bus.core_done = 1'b0;
         repeat (CORE_LAT) @(negedge clk);
`ifdef SPI_BURST_LOOPCHK_EN
         bus.core_dout = core_shreg ^ (corrupt ? 8'h01 : 8'h00);
         core_shreg    = core_sent;
`else
         bus.core_dout = ~core_sent;
`endif
         bus.core_done = 1'b1;
      end
   end

   // Scoreboard: every rx handshake must match the oldest expected word
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
         check("rx_expected_pending", 32'(exp_q.size() > 0), 32'h1);
         if (exp_q.size() > 0) check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic ok;
      rst           = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.tx_data   = '0;
      bus.rx_ready  = 1'b1;
      bus.core_done = 1'b1;
      bus.core_dout = '0;
`ifdef SPI_BURST_LOOPCHK_EN
      corrupt    = 1'b0;
      core_shreg = '0;
      last_sent  = '0;
`endif

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_tx_ready", 32'(bus.tx_ready), 32'h1);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
      check("rst_rx_data", 32'(bus.rx_data), 32'h0);
      check("rst_core_din", 32'(bus.core_din), 32'h0);
      check("rst_core_cs", 32'(bus.core_cs), 32'h0);
      check("rst_core_wr", 32'(bus.core_wr), 32'h0);
      check("rst_core_rd", 32'(bus.core_rd), 32'h0);
`ifdef SPI_BURST_LOOPCHK_EN
      check("rst_err", 32'(err), 32'h0);
`endif
      tick();
      rst = 1'b1;
      tick();
      tick();

      // Single word: core_wr/cs exactly one cycle after the push
      push_word(8'hAA);
      @(negedge clk);
      check("t1_wr_not_early", 32'(bus.core_wr), 32'h0);
      @(negedge clk);
      check("t1_wr", 32'(bus.core_wr), 32'h1);
      check("t1_cs", 32'(bus.core_cs), 32'h1);
      check("t1_rd", 32'(bus.core_rd), 32'h0);
      check("t1_din", 32'(bus.core_din), 32'hAA);
      check("t1_busy", 32'(busy), 32'h1);
      @(negedge clk);
      check("t1_wr_one_cycle", 32'(bus.core_wr), 32'h0);
      check("t1_cs_one_cycle", 32'(bus.core_cs), 32'h0);
      wait_idle("t1_idle");
      check("t1_din_held", 32'(bus.core_din), 32'hAA);

      // Fill the FIFO with the core held busy; fifth word waits for a pop
      tick();
      bus.core_done = 1'b0;
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      push_word(8'h44);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h55;
      exp_push(8'h55);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_full_tx_ready", 32'(bus.tx_ready), 32'h0);
         check("t2_no_load", 32'(bus.core_wr), 32'h0);
      end
      check("t2_busy", 32'(busy), 32'h1);
      bus.core_done = 1'b1;
      @(negedge clk);
      check("t2_pop_load", 32'(bus.core_wr), 32'h1);
      check("t2_pop_din", 32'(bus.core_din), 32'h11);
      check("t2_tx_ready_after_pop", 32'(bus.tx_ready), 32'h1);
      tick();
      bus.tx_valid = 1'b0;
      wait_idle("t2_idle");

      // Back-to-back burst: next LOAD directly follows CAPTURE
      tick();
      push_word(8'h01);
      push_word(8'h02);
      wait_rx_valid("t3_first_rx");
      check("t3_no_idle_gap", 32'(bus.core_wr), 32'h1);
      check("t3_din_second", 32'(bus.core_din), 32'h02);
      wait_idle("t3_idle");

      // rx backpressure: stall in CAPTURE, hold first word, no further LOAD
      tick();
      bus.rx_ready = 1'b0;
      push_word(8'h5A);
      push_word(8'h6B);
      push_word(8'h7C);
      wait_rx_valid("t4_first_rx");
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.core_wr === 1'b1) cnt++;
         @(negedge clk);
      end
      check("t4_single_load_while_stalled", 32'(cnt), 32'h1);
      check("t4_rx_valid_held", 32'(bus.rx_valid), 32'h1);
      check("t4_rx_data_held", 32'(bus.rx_data), 32'(exp_q[0]));
      check("t4_busy", 32'(busy), 32'h1);
      tick();
      bus.rx_ready = 1'b1;
      wait_idle("t4_idle");

      // Reset during WAIT_DONE aborts the transfer
      tick();
      push_word(8'h99);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.core_wr === 1'b1) ok = 1'b1;
      end
      check("t5_load_seen", 32'(ok), 32'h1);
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_rx_valid", 32'(bus.rx_valid), 32'h0);
      check("t5_rx_data", 32'(bus.rx_data), 32'h0);
      check("t5_core_din", 32'(bus.core_din), 32'h0);
      check("t5_core_cs", 32'(bus.core_cs), 32'h0);
      check("t5_core_wr", 32'(bus.core_wr), 32'h0);
      check("t5_tx_ready", 32'(bus.tx_ready), 32'h1);
`ifdef SPI_BURST_LOOPCHK_EN
      check("t5_err", 32'(err), 32'h0);
`endif
      exp_q.delete();
      tick();
      tick();
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rx_valid === 1'b1) cnt++;
      end
      check("t5_no_rx_after_abort", 32'(cnt), 32'h0);

      // First LOAD after reset waits for core_done
      tick();
      bus.core_done = 1'b0;
      push_word(8'h3C);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.core_wr === 1'b1) cnt++;
      end
      check("t5_load_waits_done", 32'(cnt), 32'h0);
      bus.core_done = 1'b1;
      @(negedge clk);
      check("t5_load_after_done", 32'(bus.core_wr), 32'h1);
      check("t5_din_after_done", 32'(bus.core_din), 32'h3C);
      wait_idle("t5_idle");

`ifdef SPI_BURST_LOOPCHK_EN
      // Clean loopback traffic keeps err low; a corrupted echo sets it for good
      tick();
      push_word(8'hA5);
      push_word(8'h3C);
      wait_idle("t6_clean_idle");
      check("t6_err_clean", 32'(err), 32'h0);
      tick();
      corrupt = 1'b1;
      push_word(8'h5A);
      wait_idle("t6_corrupt_idle");
      corrupt = 1'b0;
      check("t6_err_set", 32'(err), 32'h1);
      tick();
      push_word(8'hC3);
      wait_idle("t6_sticky_idle");
      check("t6_err_sticky", 32'(err), 32'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_burst_ctrl.md
SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

Interface
REQ-001 Parameter DWIDTH, default 8, SHALL set the SPI word width in bits.
REQ-002 Parameter DEPTH, default 4, power of two >= 2, SHALL set the TX FIFO depth in words.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port tx_valid/tx_ready/tx_data, in/out/in, 1/1/DWIDTH: upstream word push handshake.
REQ-006 Port rx_valid/rx_ready/rx_data, out/in/out, 1/1/DWIDTH: downstream received-word handshake.
REQ-007 Port busy, output, 1: high whenever the FSM is not IDLE or the TX FIFO is non-empty.
REQ-008 Port core_cs/core_rd/core_wr, output, 1 each: strobes to spi_core.
REQ-009 Port core_din, output, DWIDTH: word to spi_core.
REQ-010 Port core_dout/core_done, input, DWIDTH/1: result and completion from spi_core.
REQ-011 Port err, output, 1: sticky loopback mismatch flag, present only when the macro of REQ-030 is defined.

Function
REQ-012 TX FIFO push SHALL occur on tx_valid & tx_ready; tx_ready SHALL equal "FIFO not full".
REQ-013 Simultaneous push and pop on a full FIFO SHALL NOT be accepted; tx_ready stays low that cycle.
REQ-014 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-015 FSM states SHALL be IDLE, LOAD, WAIT_START, WAIT_DONE, CAPTURE.
REQ-016 IDLE -> LOAD when the FIFO is non-empty and core_done=1; otherwise stay in IDLE.
REQ-017 LOAD SHALL last exactly one cycle: pop the FIFO head onto core_din, assert core_cs=1 and core_wr=1, keep core_rd=0, then go to WAIT_START.
REQ-018 core_cs and core_wr SHALL be high only in LOAD; core_rd SHALL always be 0.
REQ-019 core_din SHALL hold the popped word from LOAD until the next LOAD.
REQ-020 WAIT_START -> WAIT_DONE when core_done=0.
REQ-021 WAIT_DONE -> CAPTURE when core_done=1.
REQ-022 CAPTURE SHALL load core_dout into rx_data and set rx_valid=1 only if rx_valid=0 or rx_ready=1 that cycle; otherwise it SHALL stall in CAPTURE (backpressure).
REQ-023 From CAPTURE, on a successful load, the FSM SHALL go to LOAD if the FIFO is non-empty and core_done=1, else to IDLE; back-to-back bursts therefore insert no IDLE cycle.
REQ-024 rx_valid SHALL clear on rx_valid & rx_ready unless reloaded the same cycle.
REQ-025 Latency SHALL be exactly 1 cycle from a push into an empty FIFO with FSM in IDLE and core_done=1 to core_wr=1.

Reset
REQ-026 While rst=0, the FSM SHALL be IDLE, the FIFO empty, rx_valid=0, rx_data=0, core_din=0, core_cs=core_wr=core_rd=0, and err=0.
REQ-027 Assertion of rst mid-transfer SHALL abort immediately; no rx word is produced for the aborted transfer.
REQ-028 The first LOAD after reset release SHALL wait for core_done=1.

Configuration
REQ-029 Exactly one compile-time option SHALL exist.
REQ-030 With SPI_BURST_LOOPCHK_EN defined, each captured word SHALL be compared with the word sent in the previous transfer (loopback echo of a DWIDTH-bit secondary shift register); on any mismatch err SHALL set and stay set until reset.
REQ-031 With SPI_BURST_LOOPCHK_EN defined, the first capture after reset SHALL be exempt from the comparison.
REQ-032 Without SPI_BURST_LOOPCHK_EN, the err port, the comparator, and the previous-word register SHALL be absent.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum and the default DWIDTH constant.
REQ-034 The TX FIFO SHALL be sub-module spi_sync_fifo, parameterised by DWIDTH and DEPTH.

Verification
REQ-035 Reset then push 8'hAA with core_done=1 -> core_wr=core_cs=1 for one cycle, 1 cycle later, with core_din=8'hAA.
REQ-036 Push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with no pops -> the first four are accepted and tx_ready=0 on the fifth; after a pop, 8'h55 is accepted.
REQ-037 Burst 8'h01, 8'h02 with rx_ready=1 -> rx_data sequence matches core_dout per transfer, and the second LOAD follows CAPTURE with no IDLE cycle.
REQ-038 Hold rx_ready=0 across two transfers -> the FSM stalls in CAPTURE, the first rx_data is retained, and no core_wr pulse occurs until rx_ready=1.
REQ-039 Drive rst=0 during WAIT_DONE -> all outputs return to reset values asynchronously, and rx_valid stays 0 after release.
REQ-040 With SPI_BURST_LOOPCHK_EN and a loopback shift register, send 8'hA5 then 8'h3C -> err=0; force a corrupted echo -> err=1 and sticky.
